// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth (2..256), occupancy count, programmable
// almost-full / almost-empty thresholds and synchronous flush. Illegal pushes and
// pops are dropped in hardware and recorded in sticky error flags.
//
// Read mode (FWFT):
//   1 : the head entry is presented combinationally; rd_valid_o = !empty_o.
//   0 : an accepted pop registers the head into rd_data_o and pulses rd_valid_o
//       for the following cycle; rd_data_o holds otherwise.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset, highest priority
//   flush_i      synchronous empty request; overrides wr_en_i / rd_en_i
//   wr_en_i      push request
//   wr_data_i    push data
//   full_o       count_o == DEPTH
//   afull_o      count_o >= AFULL_TH
//   rd_en_i      pop request
//   rd_data_o    read data
//   rd_valid_o   rd_data_o qualifier
//   empty_o      count_o == 0
//   aempty_o     count_o <= AEMPTY_TH
//   count_o      entries currently stored
//   overflow_o   sticky: a push was rejected
//   underflow_o  sticky: a pop was rejected
//   err_clr_i    clears both sticky flags (a new error in the same cycle wins)

module sync_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = DEPTH - 1,
  parameter int unsigned AEMPTY_TH = 1,
  parameter bit          FWFT      = 1'b1,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             full_o,
  output logic             afull_o,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             empty_o,
  output logic             aempty_o,
  output logic [CW-1:0]    count_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             err_clr_i
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Parameter legality, caught at elaboration.
  if (WIDTH < 1 || WIDTH > 512) begin : g_bad_width
    $error("sync_fifo: WIDTH must be in 1..512");
  end
  if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be in 2..256");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("sync_fifo: AFULL_TH must be in 1..DEPTH");
  end
  if (AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo: AEMPTY_TH must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic empty, full;
  logic rd_acc, wr_acc;
  logic ovf_set, unf_set;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));

    // Flush suppresses both requests, including their error side effects.
    rd_acc  = !flush_i && rd_en_i && !empty;
    wr_acc  = !flush_i && wr_en_i && (!full || rd_acc);
    ovf_set = !flush_i && wr_en_i && !wr_acc;
    unf_set = !flush_i && rd_en_i && empty;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Set has priority over clear.
    overflow_d  = ovf_set || (overflow_q && !err_clr_i);
    underflow_d = unf_set || (underflow_q && !err_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; flush and reset only move the pointers.
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_comb begin
    full_o      = full;
    empty_o     = empty;
    afull_o     = (count_q >= CW'(AFULL_TH));
    aempty_o    = (count_q <= CW'(AEMPTY_TH));
    count_o     = count_q;
    overflow_o  = overflow_q;
    underflow_o = underflow_q;
  end

  if (FWFT) begin : g_fwft
    always_comb begin
      rd_data_o  = mem_q[rd_ptr_q];
      rd_valid_o = !empty;
    end
  end else begin : g_reg_read
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;

    // rd_acc is already low during flush, so the valid pulse is suppressed there.
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        rd_valid_q <= rd_acc;
      end
    end

    always_comb begin
      rd_data_o  = rd_data_q;
      rd_valid_o = rd_valid_q;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i && !flush_i && wr_en_i && full && !rd_acc) begin
      $warning("sync_fifo: push dropped while full");
    end
    if (!reset_i && !flush_i && rd_en_i && empty) begin
      $warning("sync_fifo: pop dropped while empty");
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Two instances (DEPTH=5, AFULL_TH=4, AEMPTY_TH=1): one FWFT, one registered-read.
// Both share the same stimulus and are compared every cycle against a queue model.
module tb_sync_fifo;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 5;
  localparam int unsigned AF = 4;
  localparam int unsigned AE = 1;
  localparam int unsigned CW = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] wr_data = '0;

  logic          full_a, afull_a, empty_a, aempty_a, rd_valid_a, ovf_a, unf_a;
  logic [W-1:0]  rd_data_a;
  logic [CW-1:0] count_a;
  logic          full_b, afull_b, empty_b, aempty_b, rd_valid_b, ovf_b, unf_b;
  logic [W-1:0]  rd_data_b;
  logic [CW-1:0] count_b;

  always #5 clk = ~clk;

  sync_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b1)) u_fwft (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full_a), .afull_o(afull_a), .rd_en_i(rd_en), .rd_data_o(rd_data_a),
    .rd_valid_o(rd_valid_a), .empty_o(empty_a), .aempty_o(aempty_a), .count_o(count_a),
    .overflow_o(ovf_a), .underflow_o(unf_a), .err_clr_i(err_clr)
  );

  sync_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1'b0)) u_reg (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .wr_en_i(wr_en), .wr_data_i(wr_data),
    .full_o(full_b), .afull_o(afull_b), .rd_en_i(rd_en), .rd_data_o(rd_data_b),
    .rd_valid_o(rd_valid_b), .empty_o(empty_b), .aempty_o(aempty_b), .count_o(count_b),
    .overflow_o(ovf_b), .underflow_o(unf_b), .err_clr_i(err_clr)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: contents as a queue, flags as plain bits.
  logic [W-1:0] mq[$];
  bit           m_ok  = 1'b0;
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;
  bit           m_rv  = 1'b0;
  logic [W-1:0] m_rd  = '0;

  // Inputs are driven just after a rising edge, so at the falling edge they are the
  // values the next rising edge will sample: compare first, then advance the model.
  always @(negedge clk) begin : scoreboard
    int  n;
    bit  racc, wacc;
    n = mq.size();
    if (m_ok) begin
      check("count_a",  32'(count_a),  32'(n));
      check("count_b",  32'(count_b),  32'(n));
      check("empty_a",  32'(empty_a),  32'(n == 0));
      check("empty_b",  32'(empty_b),  32'(n == 0));
      check("full_a",   32'(full_a),   32'(n == D));
      check("full_b",   32'(full_b),   32'(n == D));
      check("afull_a",  32'(afull_a),  32'(n >= AF));
      check("afull_b",  32'(afull_b),  32'(n >= AF));
      check("aempty_a", 32'(aempty_a), 32'(n <= AE));
      check("aempty_b", 32'(aempty_b), 32'(n <= AE));
      check("ovf_a",    32'(ovf_a),    32'(m_ovf));
      check("ovf_b",    32'(ovf_b),    32'(m_ovf));
      check("unf_a",    32'(unf_a),    32'(m_unf));
      check("unf_b",    32'(unf_b),    32'(m_unf));
      check("rd_valid_a", 32'(rd_valid_a), 32'(n > 0));
      if (n > 0) check("rd_data_a", 32'(rd_data_a), 32'(mq[0]));
      check("rd_valid_b", 32'(rd_valid_b), 32'(m_rv));
      check("rd_data_b",  32'(rd_data_b),  32'(m_rd));
    end
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = '0;
      m_ok  = 1'b1;
    end else if (flush) begin
      mq.delete();
      m_rv = 1'b0;
      if (err_clr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
    end else begin
      racc  = rd_en && (n > 0);
      wacc  = wr_en && ((n < D) || racc);
      m_ovf = (wr_en && !wacc) || (m_ovf && !err_clr);
      m_unf = (rd_en && n == 0) || (m_unf && !err_clr);
      m_rv  = racc;
      if (racc) m_rd = mq.pop_front();
      if (wacc) mq.push_back(wr_data);
    end
  end

  task automatic cyc(input bit w, input logic [W-1:0] d, input bit r,
                     input bit f = 1'b0, input bit ec = 1'b0, input bit rs = 1'b0);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    flush   = f;
    err_clr = ec;
    reset   = rs;
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_tail [5] = '{8'h25, 8'h26, 8'h27, 8'h28, 8'hAA};

  initial begin
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    check("rst_count",   32'(count_a),   0);
    check("rst_empty",   32'(empty_a),   1);
    check("rst_full",    32'(full_a),    0);
    check("rst_afull",   32'(afull_a),   0);
    check("rst_aempty",  32'(aempty_a),  1);
    check("rst_rvalid",  32'(rd_valid_b), 0);
    check("rst_rdata",   32'(rd_data_b), 0);
    check("rst_ovf",     32'(ovf_b),     0);

    // Fill, with threshold crossings on the way up.
    for (int i = 0; i < 5; i++) begin
      cyc(1, W'(8'h11 + i), 0);
      check("fill_count", 32'(count_a), 32'(i + 1));
      if (i == 0) check("th_c1_aempty", 32'(aempty_a), 1);
      if (i == 0) check("th_c1_afull",  32'(afull_a),  0);
      if (i == 1) check("th_c2_aempty", 32'(aempty_a), 0);
      if (i == 3) check("th_c4_afull",  32'(afull_a),  1);
    end
    check("fill_full", 32'(full_a), 1);

    // Drain.
    for (int i = 0; i < 5; i++) begin
      check("fwft_head", 32'(rd_data_a), 32'(8'h11 + i));
      cyc(0, 0, 1);
      check("reg_rvalid", 32'(rd_valid_b), 1);
      check("reg_rdata",  32'(rd_data_b),  32'(8'h11 + i));
      if (i == 1) check("th_c3_afull", 32'(afull_a), 0);
    end
    check("drain_empty", 32'(empty_a), 1);
    check("drain_ovf",   32'(ovf_a),   0);
    check("drain_unf",   32'(unf_a),   0);
    cyc(0, 0, 0);
    check("reg_rvalid_drop", 32'(rd_valid_b), 0);

    // Wrap-around: pointers move past DEPTH-1.
    for (int i = 0; i < 3; i++) cyc(1, W'(8'h21 + i), 0);
    for (int i = 0; i < 3; i++) begin
      check("wrap_head", 32'(rd_data_a), 32'(8'h21 + i));
      cyc(1, W'(8'h24 + i), 1);
      check("wrap_count", 32'(count_a), 3);
    end
    cyc(1, 8'h27, 0);
    cyc(1, 8'h28, 0);
    check("refill_count", 32'(count_a), 5);

    // Simultaneous push/pop while full.
    check("full_head", 32'(rd_data_a), 32'h24);
    cyc(1, 8'hAA, 1);
    check("fullpp_count", 32'(count_a), 5);
    check("fullpp_ovf",   32'(ovf_a),   0);
    check("fullpp_rdata", 32'(rd_data_b), 32'h24);
    cyc(1, 8'hBB, 0);
    check("ovf_set",   32'(ovf_a),   1);
    check("ovf_count", 32'(count_a), 5);
    for (int i = 0; i < 5; i++) begin
      check("tail_head", 32'(rd_data_a), 32'(exp_tail[i]));
      cyc(0, 0, 1);
    end
    cyc(0, 0, 0, 0, 1);
    check("ovf_clr", 32'(ovf_a), 0);

    // Registered-read latency and underflow.
    cyc(1, 8'h3C, 0);
    cyc(0, 0, 1);
    check("lat_rvalid", 32'(rd_valid_b), 1);
    check("lat_rdata",  32'(rd_data_b),  32'h3C);
    cyc(0, 0, 0);
    check("lat_rvalid_low", 32'(rd_valid_b), 0);
    check("lat_rdata_hold", 32'(rd_data_b),  32'h3C);
    cyc(0, 0, 1);
    check("unf_set",    32'(unf_b),      1);
    check("unf_rvalid", 32'(rd_valid_b), 0);
    cyc(0, 0, 1, 0, 1);
    check("unf_set_wins", 32'(unf_b), 1);
    cyc(0, 0, 0, 0, 1);
    check("unf_clr", 32'(unf_b), 0);

    // Push and pop on empty: push only.
    cyc(1, 8'h5A, 1);
    check("pe_unf",    32'(unf_a),   1);
    check("pe_count",  32'(count_a), 1);
    check("pe_rvalid", 32'(rd_valid_b), 0);
    check("pe_head",   32'(rd_data_a), 32'h5A);
    cyc(0, 0, 1);

    // Flush with push and pop; underflow is still set and must stay set.
    for (int i = 0; i < 3; i++) cyc(1, W'(8'h41 + i), 0);
    check("pre_flush_count", 32'(count_a), 3);
    cyc(1, 8'h44, 1, 1);
    check("flush_count",  32'(count_a),    0);
    check("flush_empty",  32'(empty_a),    1);
    check("flush_unf",    32'(unf_a),      1);
    check("flush_ovf",    32'(ovf_a),      0);
    check("flush_rvalid", 32'(rd_valid_b), 0);
    cyc(1, 8'h61, 0, 0, 1);
    check("post_flush_head", 32'(rd_data_a), 32'h61);
    cyc(0, 0, 1);

    // Reset in the middle of a registered read.
    cyc(0, 0, 1);
    cyc(1, 8'h51, 0);
    cyc(1, 8'h52, 0);
    cyc(0, 0, 1);
    check("pre_rst_rvalid", 32'(rd_valid_b), 1);
    cyc(1, 8'h53, 1, 0, 0, 1);
    check("midrst_rvalid", 32'(rd_valid_b), 0);
    check("midrst_count",  32'(count_b),    0);
    check("midrst_unf",    32'(unf_b),      0);
    check("midrst_ovf",    32'(ovf_b),      0);
    check("midrst_rdata",  32'(rd_data_b),  0);
    repeat (3) cyc(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
